mult_sequencer: RTL and testbench

MULT_SEQUENCER -- requirements
Module: mult_sequencer

---
 rtl/mult_pkg.sv | 45 ++++
 rtl/mult_byte_pack.sv | 63 ++++++
 rtl/mult_sequencer.sv | 179 +++++++++++++++++
 tb/tb_mult_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared constants, sizing helper and sequencer state type for
//                the ternary-multiplier byte sequencer.
//                Optional feature macro: MULT_SEQ_CMD_EN (adds the S_CMD
//                command state that selects weight reload or weight reuse).
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Ternary weights per weight word (two rows of 7 two-bit codes)
    localparam int IN_LEN    = 14;
    // Output lanes, also the number of rows in one frame
    localparam int OUT_LEN   = 7;
    // Activation width and byte width of the input stream
    localparam int BIT_WIDTH = 8;

    // Number of stream bytes needed to carry a field of the given bit width
    function automatic int bytes_for(input int bits, input int bw);
        return (bits + bw - 1) / bw;
    endfunction

    // Bytes per weight word: ceil(2*IN_LEN / BIT_WIDTH)
    localparam int W_BYTES = bytes_for(2 * IN_LEN, BIT_WIDTH);

    // Sequencer states; S_CMD only exists when the command feature is built
    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_STREAM = 2'd1,
`ifdef MULT_SEQ_CMD_EN
        S_CMD    = 2'd3,
`endif
        S_DONE   = 2'd2
    } state_t;

    // State entered after reset and after every completed frame
`ifdef MULT_SEQ_CMD_EN
    localparam state_t S_START = S_CMD;
`else
    localparam state_t S_START = S_LOAD;
`endif

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_byte_pack.sv
`default_nettype none
// ============================================================================
//  Module      : mult_byte_pack
//  Description : Little-endian byte-to-word assembler. Earlier bytes of a
//                word are held in a shift register; when the final byte is
//                taken, the completed word is presented combinationally
//                together with a one-cycle completion flag so the parent can
//                register it atomically. Bits beyond OutWidth are dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_byte_pack #(
    parameter int NBytes   = 2,
    parameter int BitWidth = 8,
    parameter int OutWidth = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                take,
    input  logic [BitWidth-1:0] data,
    output logic [OutWidth-1:0] word,
    output logic                done
);

    localparam int CW = (NBytes > 1) ? $clog2(NBytes) : 1;

    logic [CW-1:0] cnt;

    // The word completes on the take that carries its last byte
    assign done = take && (cnt == CW'(NBytes - 1));

    // Byte position counter; wraps to zero once a word completes
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (take) begin
            cnt <= done ? '0 : cnt + CW'(1);
        end
    end

    generate
        if (NBytes > 1) begin : g_shift
            localparam int SRW = (NBytes - 1) * BitWidth;

            logic [SRW-1:0] sr;

            // New bytes enter at the top so byte 0 ends up at the bottom
            always_ff @(posedge clk) begin
                if (rst) begin
                    sr <= '0;
                end else if (take) begin
                    sr <= (sr >> BitWidth) | (SRW'(data) << ((NBytes - 2) * BitWidth));
                end
            end

            // Final byte lands in the top slot; surplus upper bits fall off
            assign word = OutWidth'({data, sr});
        end else begin : g_single
            assign word = OutWidth'(data);
        end
    endgenerate

endmodule : mult_byte_pack
`default_nettype wire

// File: rtl/mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mult_sequencer
//  Description : Turns a byte stream into weight words and activation pairs
//                for a ternary multiplier. Each frame loads one weight word
//                (W_BYTES bytes, little-endian), then streams OutLen rows of
//                two activation bytes, strobing en once per row, and ends
//                with a one-cycle frame_done.
//                Optional feature macro: MULT_SEQ_CMD_EN -- each frame starts
//                with a command byte; cmd[0]=1 reloads weights, cmd[0]=0
//                reuses the current W.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int InLen    = IN_LEN,
    parameter int OutLen   = OUT_LEN,
    parameter int BitWidth = BIT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BitWidth-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [2*InLen-1:0]    W,
    output logic [2*BitWidth-1:0] VecIn,
    output logic [2:0]            row,
    output logic                  en,
    output logic                  frame_done
);

    localparam int WW = 2 * InLen;
    localparam int VW = 2 * BitWidth;
    localparam int WB = bytes_for(WW, BitWidth);

    state_t           state;
    state_t           state_nxt;
    logic             take;
    logic             w_take;
    logic             a_take;
    logic             w_done;
    logic             a_done;
    logic [WW-1:0]    w_word;
    logic [VW-1:0]    a_word;
    logic             last_row;

    assign last_row = (row == 3'(OutLen - 1));

    // Weight shadow: W_BYTES bytes assembled into one weight word
    mult_byte_pack #(
        .NBytes   (WB),
        .BitWidth (BitWidth),
        .OutWidth (WW)
    ) u_wpack (
        .clk  (clk),
        .rst  (rst),
        .take (w_take),
        .data (in_data),
        .word (w_word),
        .done (w_done)
    );

    // Activation staging: two bytes per row, low byte first
    mult_byte_pack #(
        .NBytes   (2),
        .BitWidth (BitWidth),
        .OutWidth (VW)
    ) u_apack (
        .clk  (clk),
        .rst  (rst),
        .take (a_take),
        .data (in_data),
        .word (a_word),
        .done (a_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_START;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
`ifdef MULT_SEQ_CMD_EN
            S_CMD: begin
                if (take) begin
                    state_nxt = in_data[0] ? S_LOAD : S_STREAM;
                end
            end
`endif
            S_LOAD: begin
                if (w_done) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                // Leave once the strobe for the final row has been shown
                if (en && last_row) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_START;
            end
            default: begin
                state_nxt = S_START;
            end
        endcase
    end

    // Output / handshake decode; ready is held off during reset and while
    // a row strobe is on the bus so the row index can advance cleanly
    always_comb begin
        in_ready   = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_LOAD, S_STREAM: begin
                in_ready = !rst && !en;
            end
`ifdef MULT_SEQ_CMD_EN
            S_CMD: begin
                in_ready = !rst;
            end
`endif
            S_DONE: begin
                frame_done = !rst;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
        take   = in_valid && in_ready;
        w_take = take && (state == S_LOAD);
        a_take = take && (state == S_STREAM);
    end

    // Weight word: replaced only with a complete shadow, never partially
    always_ff @(posedge clk) begin
        if (rst) begin
            W <= '0;
        end else if (w_done) begin
            W <= w_word;
        end
    end

    // Activation pair and its one-cycle strobe; VecIn holds between rows
    always_ff @(posedge clk) begin
        if (rst) begin
            VecIn <= '0;
            en    <= 1'b0;
        end else begin
            en <= a_done;
            if (a_done) begin
                VecIn <= a_word;
            end
        end
    end

    // Row index: advances after each strobe, wraps after the last row,
    // and is held at zero for the frame-end cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
        end else if (state == S_DONE) begin
            row <= '0;
        end else if (en) begin
            row <= last_row ? 3'd0 : row + 3'd1;
        end
    end

endmodule : mult_sequencer
`default_nettype wire

// File: tb/tb_mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_sequencer
//  Description : Scoreboard bench for mult_sequencer. The driver pushes the
//                expected row strobes and frame ends; a monitor pops and
//                compares whenever en or frame_done appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_sequencer;

    localparam int IL = 14;
    localparam int OL = 7;
    localparam int BW = 8;

    typedef struct packed {
        logic [2*IL-1:0] w;
        logic [2*BW-1:0] v;
        logic [2:0]      r;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [BW-1:0]   in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2*IL-1:0] W;
    logic [2*BW-1:0] VecIn;
    logic [2:0]      row;
    logic            en;
    logic            frame_done;

    exp_t exp_q[$];
    int   done_exp = 0;
    bit   mid_pair = 1'b0;
    bit   prev_en  = 1'b0;
    logic [2:0] prev_row = '0;
    int   n_total = 0;
    int   n_pass  = 0;

    mult_sequencer #(
        .InLen    (IL),
        .OutLen   (OL),
        .BitWidth (BW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .W          (W),
        .VecIn      (VecIn),
        .row        (row),
        .en         (en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Present one byte and hold it until accepted; optionally insert gaps
    task automatic send(input logic [7:0] b, input bit stall, input int mid_mode);
        int g;
        int n;
        g = 0;
        if (stall) begin
            while ($urandom_range(0, 2) != 0 && g < 6) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
                g++;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (mid_mode == 1) mid_pair = 1'b1;
        else if (mid_mode == 2) mid_pair = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // One frame; abort_row >= 0 resets after the first byte of that row
    task automatic frame(input bit load, input logic [31:0] wb, input logic [27:0] expw,
                         input bit stall, input int abort_row);
        exp_t e;
`ifdef MULT_SEQ_CMD_EN
        send(load ? 8'h01 : 8'h00, stall, 0);
`endif
        if (load) begin
            for (int k = 0; k < 4; k++) send(wb[8*k +: 8], stall, 0);
        end
        for (int i = 0; i < OL; i++) begin
            if (i == abort_row) begin
                send(8'(i), stall, 1);
                rst = 1'b1;
                mid_pair = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                #1;
                chk("in_ready_after_abort", 32'(in_ready), 32'd1);
                @(negedge clk);
                return;
            end
            e.w = expw;
            e.v = {8'(8'h80 + i), 8'(i)};
            e.r = 3'(i);
            exp_q.push_back(e);
            send(8'(i), stall, 1);
            if (i == OL - 1) done_exp++;
            send(8'(8'h80 + i), stall, 2);
        end
    endtask

    // Monitor: compare every strobe against the scoreboard
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (!rst) begin
            if (en) begin
                chk("en_expected", 32'(exp_q.size() != 0), 32'd1);
                chk("en_mid_pair", 32'(mid_pair), 32'd0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("row", 32'(row), 32'(e.r));
                    chk("VecIn", 32'(VecIn), 32'(e.v));
                    chk("W", 32'(W), 32'(e.w));
                end
            end
            if (frame_done) begin
                chk("done_expected", 32'(done_exp > 0), 32'd1);
                if (done_exp > 0) done_exp--;
                chk("done_after_last_en", {28'd0, prev_en, prev_row}, {28'd0, 1'b1, 3'(OL - 1)});
                chk("row_zero_in_done", 32'(row), 32'd0);
            end
            prev_en  = en;
            prev_row = row;
        end else begin
            prev_en  = 1'b0;
            prev_row = '0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held three cycles with traffic offered
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hA5;
        repeat (3) @(negedge clk);
        chk("rst_W", 32'(W), 32'd0);
        chk("rst_VecIn", 32'(VecIn), 32'd0);
        chk("rst_row", 32'(row), 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Full frame, back to back
        frame(1'b1, 32'h05555555, 28'h5555555, 1'b0, -1);
        // Same frame with random valid gaps
        frame(1'b1, 32'h05555555, 28'h5555555, 1'b1, -1);
        // Abort during row 3, then a clean frame with new weights
        frame(1'b1, 32'h05555555, 28'h5555555, 1'b0, 3);
        frame(1'b1, 32'h07563412, 28'h7563412, 1'b0, -1);
        // Upper nibble of the final weight byte is discarded
        frame(1'b1, 32'hF3555555, 28'h3555555, 1'b0, -1);
`ifdef MULT_SEQ_CMD_EN
        // Load all-ones weights, then reuse them without reloading
        frame(1'b1, 32'h0FFFFFFF, 28'hFFFFFFF, 1'b0, -1);
        frame(1'b0, 32'h00000000, 28'hFFFFFFF, 1'b1, -1);
`endif
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("frame_done_drained", 32'(done_exp), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mult_sequencer
`default_nettype wire
